// File: rtl/uart_serializer.sv
// UART serializer: packets are queued in a small FIFO and sent as
// frames of start(0), PKT_SIZE data bits MSb first, optional even
// parity, stop(1). Each bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: UART_SERIALIZER_PARITY_EN (adds PARITY bit).
// Ports:
//   clock    - sole clock, rising edge
//   reset    - synchronous, active-high
//   io_pkt   - packet to queue, sampled with io_req
//   io_req   - push request, honoured only while io_ready=1
//   io_ready - FIFO not full
//   io_done  - one-cycle pulse in the last cycle of each stop bit
//   io_tx    - registered serial line, idles high
module uart_serializer #(
    parameter int PKT_SIZE     = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PKT_SIZE-1:0] io_pkt,
    input  logic                io_req,
    output logic                io_ready,
    output logic                io_done,
    output logic                io_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (PKT_SIZE > 1) ? $clog2(PKT_SIZE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PKT_SIZE - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, START, DATA, STOP
    } state_t;
`endif

    // FIFO
    logic [PKT_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                push;
    logic                pop;
    logic                empty;

    assign io_ready = (count != FULL_CNT);
    assign empty    = (count == '0);
    assign push     = io_req && io_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= io_pkt;
    end

    // Frame FSM
    state_t              state;
    state_t              state_n;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_n;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_n;
    logic [PKT_SIZE-1:0] shreg;
    logic [PKT_SIZE-1:0] shreg_n;
    logic                bit_end;
    logic                tx_n;
    logic                done_n;
`ifdef UART_SERIALIZER_PARITY_EN
    logic                par;
    logic                par_n;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shreg_n = shreg;
        pop     = 1'b0;
        bit_end = (cnt == CNT_LAST);
        cnt_n   = bit_end ? '0 : cnt + 1'b1;
`ifdef UART_SERIALIZER_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == IDX_LAST) begin
`ifdef UART_SERIALIZER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg << 1;
                    end
                end
            end
`ifdef UART_SERIALIZER_PARITY_EN
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                // Pop straight into START so frames run gap-free
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (pop) begin
            shreg_n = mem[rd_ptr];
`ifdef UART_SERIALIZER_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
        end

        // Outputs are registered from the next state
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[PKT_SIZE-1];
`ifdef UART_SERIALIZER_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
        done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            io_tx   <= 1'b1;
            io_done <= 1'b0;
`ifdef UART_SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            io_tx   <= tx_n;
            io_done <= done_n;
`ifdef UART_SERIALIZER_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_serializer.sv
// Self-checking bench for uart_serializer: scoreboard of pushed
// packets checked against frames decoded from io_tx.
module tb_uart_serializer;

    localparam int PKT = 8;
`ifdef UART_SERIALIZER_PARITY_EN
    localparam int FW = PKT + 3;
`else
    localparam int FW = PKT + 2;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [PKT-1:0] io_pkt = '0;
    logic           io_req = 1'b0;
    logic           io_ready;
    logic           io_done;
    logic           io_tx;

    logic [PKT-1:0] pkt3 = '0;
    logic           req3 = 1'b0;
    logic           ready3;
    logic           done3;
    logic           tx3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    uart_serializer #(
        .PKT_SIZE(PKT), .FIFO_DEPTH(4), .CLKS_PER_BIT(1)
    ) dut (
        .clock(clock), .reset(reset),
        .io_pkt(io_pkt), .io_req(io_req),
        .io_ready(io_ready), .io_done(io_done), .io_tx(io_tx)
    );

    uart_serializer #(
        .PKT_SIZE(PKT), .FIFO_DEPTH(4), .CLKS_PER_BIT(3)
    ) dut3 (
        .clock(clock), .reset(reset),
        .io_pkt(pkt3), .io_req(req3),
        .io_ready(ready3), .io_done(done3), .io_tx(tx3)
    );

    function automatic logic [FW-1:0] exp_frame(logic [PKT-1:0] p);
`ifdef UART_SERIALIZER_PARITY_EN
        return {1'b0, p, ^p, 1'b1};
`else
        return {1'b0, p, 1'b1};
`endif
    endfunction

    // Scoreboard and monitor
    logic [PKT-1:0] sb[$];
    int             done_t[$];
    int             cyc = 0;
    int             pos = -1;
    logic [FW-1:0]  frame;
    logic [FW-1:0]  cur;
    logic           done_bad;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            pos = -1;
        end else begin
            if (pos < 0 && io_tx === 1'b0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: tx=0 at cyc %0d, need idle", cyc);
                end else begin
                    cur      = exp_frame(sb.pop_front());
                    pos      = 0;
                    frame    = '0;
                    done_bad = 1'b0;
                end
            end
            if (pos >= 0) begin
                frame = {frame[FW-2:0], io_tx};
                if (pos == FW - 1) begin
                    n_checks++;
                    if (frame !== cur || done_bad || io_done !== 1'b1)
                        $display("FAIL frame: got %b early_done=%0b last_done=%b, need %b",
                                 frame, done_bad, io_done, cur);
                    else
                        n_pass++;
                    done_t.push_back(cyc);
                    pos = -1;
                end else begin
                    if (io_done !== 1'b0) done_bad = 1'b1;
                    pos++;
                end
            end else if (io_done !== 1'b0) begin
                n_checks++;
                $display("FAIL stray_done: got %b at cyc %0d, need 0", io_done, cyc);
            end
        end
    end

    // Push one packet; resting point is negedge+1
    task automatic drive(input logic [PKT-1:0] p, input logic acc);
        io_pkt = p;
        io_req = 1'b1;
        n_checks++;
        if (io_ready !== acc)
            $display("FAIL ready_%h: got %b, need %b", p, io_ready, acc);
        else
            n_pass++;
        @(posedge clock);
        if (acc) sb.push_back(p);
        @(negedge clock);
        #1;
        io_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || pos >= 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if (sb.size() != 0 || pos >= 0)
            $display("FAIL drain_timeout: got %0d pending, need 0", sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        io_req = 1'b1;
        io_pkt = 8'hA5;
        repeat (3) @(negedge clock);
        n_checks += 3;
        if (io_tx !== 1'b1) $display("FAIL rst_tx: got %b, need 1", io_tx);
        else n_pass++;
        if (io_done !== 1'b0) $display("FAIL rst_done: got %b, need 0", io_done);
        else n_pass++;
        if (io_ready !== 1'b1) $display("FAIL rst_ready: got %b, need 1", io_ready);
        else n_pass++;
        #1;
        io_req = 1'b0;
        reset  = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        n_checks++;
        if (io_tx !== 1'b1) $display("FAIL rst_req_ignored: got tx %b, need 1", io_tx);
        else n_pass++;
    endtask

    task automatic test_basic();
        int t0;
        done_t.delete();
        drive(8'hCD, 1'b1);
        t0 = cyc;
        n_checks++;
        if (io_tx !== 1'b1) $display("FAIL pre_start: got %b, need 1", io_tx);
        else n_pass++;
        @(negedge clock);
        #1;
        n_checks++;
        if (io_tx !== 1'b0) $display("FAIL latency: got %b, need 0", io_tx);
        else n_pass++;
        wait_idle(40);
        n_checks++;
        if (done_t.size() != 1 || done_t[0] - t0 != FW)
            $display("FAIL done_time: got %0d pulses, need 1 at +%0d", done_t.size(), FW);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        done_t.delete();
        drive(8'hAA, 1'b1);
        drive(8'h55, 1'b1);
        wait_idle(60);
        n_checks++;
        if (done_t.size() != 2 || done_t[1] - done_t[0] != FW)
            $display("FAIL b2b_gap: got %0d pulses, need 2 spaced %0d", done_t.size(), FW);
        else
            n_pass++;
    endtask

    task automatic test_full();
        drive(8'h11, 1'b1);
        drive(8'h22, 1'b1);
        drive(8'h33, 1'b1);
        drive(8'h44, 1'b1);
        drive(8'h5A, 1'b1);
        drive(8'h66, 1'b0);
        wait_idle(120);
    endtask

    task automatic test_reset_mid();
        drive(8'hFE, 1'b1);
        drive(8'h12, 1'b1);
        drive(8'h34, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        done_t.delete();
        reset = 1'b1;
        @(negedge clock);
        n_checks += 3;
        if (io_tx !== 1'b1) $display("FAIL abort_tx: got %b, need 1", io_tx);
        else n_pass++;
        if (io_done !== 1'b0) $display("FAIL abort_done: got %b, need 0", io_done);
        else n_pass++;
        if (io_ready !== 1'b1) $display("FAIL abort_ready: got %b, need 1", io_ready);
        else n_pass++;
        #1;
        reset = 1'b0;
        sb.delete();
        begin
            int bad = 0;
            repeat (20) begin
                @(negedge clock);
                if (io_tx !== 1'b1 || io_done !== 1'b0) bad++;
            end
            #1;
            n_checks++;
            if (bad != 0 || done_t.size() != 0)
                $display("FAIL abort_flush: got %0d active cycles, need 0", bad);
            else
                n_pass++;
        end
    endtask

    task automatic test_slow_bits();
        logic [3*FW-1:0] got = '0;
        logic [3*FW-1:0] exp = '0;
        logic [FW-1:0]   f;
        int              dpos = -1;
        int              dcnt = 0;
        f = exp_frame(8'h55);
        for (int j = FW - 1; j >= 0; j--)
            exp = {exp[3*FW-4:0], {3{f[j]}}};
        pkt3 = 8'h55;
        req3 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        req3 = 1'b0;
        for (int i = 0; i < 3 * FW; i++) begin
            @(negedge clock);
            got = {got[3*FW-2:0], tx3};
            if (done3 === 1'b1) begin
                dpos = i;
                dcnt++;
            end
        end
        #1;
        n_checks += 2;
        if (got !== exp) $display("FAIL slow_bits: got %b, need %b", got, exp);
        else n_pass++;
        if (dcnt != 1 || dpos != 3 * FW - 1)
            $display("FAIL slow_done: got %0d pulses at %0d, need 1 at %0d",
                     dcnt, dpos, 3 * FW - 1);
        else
            n_pass++;
        repeat (4) @(negedge clock);
        #1;
        n_checks++;
        if (tx3 !== 1'b1 || ready3 !== 1'b1)
            $display("FAIL slow_idle: got tx %b ready %b, need 1 1", tx3, ready3);
        else
            n_pass++;
    endtask

`ifdef UART_SERIALIZER_PARITY_EN
    task automatic test_parity();
        int t0;
        done_t.delete();
        drive(8'hFE, 1'b1);
        t0 = cyc;
        wait_idle(40);
        n_checks++;
        if (done_t.size() != 1 || done_t[0] - t0 != 11)
            $display("FAIL parity_len: got %0d pulses, need 1 at +11", done_t.size());
        else
            n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_slow_bits();
`ifdef UART_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
